// File: rtl/ir_score_tracker.sv
// Per-player IR hit detector, power-up modifiers and 4-digit BCD score.
// Ports: clock/reset (async high); game_active, clear_score, ir_code[15:0],
//   double_points, snitch_powerup in; score_ones..score_thousands[3:0],
//   score_bin[13:0], hit_pulse, busy, saturated out (all registered).
module ir_score_tracker #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] TARGET_CODE     = 16'h00A5,
  parameter int unsigned HIT_POINTS      = 10,
  parameter int unsigned SNITCH_BONUS    = 150
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        game_active,
  input  logic        clear_score,
  input  logic [15:0] ir_code,
  input  logic        double_points,
  input  logic        snitch_powerup,
  output logic [3:0]  score_ones,
  output logic [3:0]  score_tens,
  output logic [3:0]  score_hundreds,
  output logic [3:0]  score_thousands,
  output logic [13:0] score_bin,
  output logic        hit_pulse,
  output logic        busy,
  output logic        saturated
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUAL,
    S_LATCH,
    S_REL
  } state_t;

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] HP      = 11'(HIT_POINTS);
  localparam logic [10:0] SB      = 11'(SNITCH_BONUS);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [9:0]  pend_q, pend_d;
  logic [3:0]  d0_q, d0_d;
  logic [3:0]  d1_q, d1_d;
  logic [3:0]  d2_q, d2_d;
  logic [3:0]  d3_q, d3_d;
  logic [13:0] bin_q, bin_d;
  logic        hit_q, hit_d;
  logic        busy_q, busy_d;
  logic        sat_q, sat_d;
  logic        snitch_q;

  logic        match;
  logic        hit_now;
  logic        snitch_rise;
  logic        drain;
  logic [10:0] pts;
  logic [10:0] add;
  logic [11:0] sum;

  assign match = (ir_code == TARGET_CODE);

  always_comb begin
    state_d = state_q;
    hit_now = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (match && game_active) state_d = S_QUAL;
      end
      S_QUAL: begin
        if (!match || !game_active) begin
          state_d = S_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_LATCH;
          hit_now = 1'b1;
        end
      end
      S_LATCH: begin
        if (!game_active)  state_d = S_IDLE;
        else if (!match)   state_d = S_REL;
      end
      S_REL: begin
        if (!game_active)         state_d = S_IDLE;
        else if (match)           state_d = S_LATCH;
        else if (cnt_q == DB_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_QUAL || state_q == S_REL)
      cnt_d = cnt_q + 20'd1;
    else
      cnt_d = cnt_q;

    if (clear_score) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign pts         = double_points ? (HP << 1) : HP;
  assign snitch_rise = snitch_powerup & ~snitch_q & game_active;
  assign add         = (hit_now ? pts : 11'd0) + (snitch_rise ? SB : 11'd0);
  assign drain       = (pend_q != 10'd0) && !sat_q;
  // drain implies pend_q >= 1, so the subtraction cannot wrap
  assign sum = {2'b00, pend_q} - {11'd0, drain} + {1'b0, add};

  always_comb begin
    pend_d = (sum > 12'd1023) ? 10'd1023 : sum[9:0];
    d0_d   = d0_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    d3_d   = d3_q;
    bin_d  = bin_q;
    sat_d  = sat_q;
    hit_d  = hit_now;

    if (drain) begin
      bin_d = bin_q + 14'd1;
      if (d0_q == 4'd9) begin
        d0_d = 4'd0;
        if (d1_q == 4'd9) begin
          d1_d = 4'd0;
          if (d2_q == 4'd9) begin
            d2_d = 4'd0;
            d3_d = d3_q + 4'd1;
          end else begin
            d2_d = d2_q + 4'd1;
          end
        end else begin
          d1_d = d1_q + 4'd1;
        end
      end else begin
        d0_d = d0_q + 4'd1;
      end
      // this step lands on 9999: freeze and drop what is left
      if (bin_q == 14'd9998) begin
        sat_d  = 1'b1;
        pend_d = '0;
      end
    end

    if (sat_q) pend_d = '0;

    if (clear_score) begin
      pend_d = '0;
      d0_d   = '0;
      d1_d   = '0;
      d2_d   = '0;
      d3_d   = '0;
      bin_d  = '0;
      sat_d  = 1'b0;
      hit_d  = 1'b0;
    end

    busy_d = (pend_d != 10'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
      bin_q    <= '0;
      hit_q    <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      snitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      bin_q    <= bin_d;
      hit_q    <= hit_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
      snitch_q <= snitch_powerup;
    end
  end

  assign score_ones      = d0_q;
  assign score_tens      = d1_q;
  assign score_hundreds  = d2_q;
  assign score_thousands = d3_q;
  assign score_bin       = bin_q;
  assign hit_pulse       = hit_q;
  assign busy            = busy_q;
  assign saturated       = sat_q;

endmodule
